uart_line_buffer: RTL and testbench

Downstream consumer of the UART receiver's byte stream. It collects received bytes into an internal line RAM until a terminator (CR 0x0D or LF 0x0A) arrives. It then replays the completed line, without the terminator, on a valid/ready byte stream. Typical sinks are the UART transmitter or a command decoder. It also gives the receiver one-line elasticity against a slow consumer.

---
 rtl/uart_line_buffer_if.sv | 26 ++
 rtl/uart_line_buffer.sv | 163 ++++++++++++++++
 tb/tb_uart_line_buffer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_line_buffer_if.sv
// Byte-stream bundle between the UART line buffer and its producer/consumer.
// The slave side is the line buffer itself; master is the environment around it.
interface uart_line_buffer_if #(
  parameter int LEN_W = 7
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_last;
  logic [LEN_W-1:0] line_len;
  logic             overflow;
  logic             drop;
  logic             busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, line_len, overflow, drop, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, line_len, overflow, drop, busy
  );
endinterface

// File: rtl/uart_line_buffer.sv
// Collects UART bytes into a line RAM until CR/LF, then replays the line on a valid/ready stream.
// Optional LINE_BUF_BACKSPACE_EN: 0x08/0x7F erase the previous byte instead of being stored.
module uart_line_buffer #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input logic           clk,
  input logic           rst,
  uart_line_buffer_if.slave bus
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] One    = LEN_W'(1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state, stateN;
  logic [LEN_W-1:0] wrPtr, wrPtrN;
  logic [LEN_W-1:0] rdPtr, rdPtrN;
  logic [LEN_W-1:0] lineLen, lineLenN;
  logic             outValid, outValidN;
  logic [7:0]       outData, outDataN;
  logic             outLast, outLastN;
  logic             overflow, overflowN;
  logic             drop, dropN;
  logic             busy, busyN;

  logic [7:0]       mem [MAX_LEN];
  logic             memWe;

  logic             isTerm;
  logic             isBackspace;
  logic [LEN_W-1:0] rdNext;
  logic [LEN_W-1:0] lastIdx;

  assign isTerm  = (bus.in_data == 8'h0D) || (bus.in_data == 8'h0A);
  assign rdNext  = rdPtr + One;
  assign lastIdx = lineLen - One;

`ifdef LINE_BUF_BACKSPACE_EN
  assign isBackspace = (bus.in_data == 8'h08) || (bus.in_data == 8'h7F);
`else
  assign isBackspace = 1'b0;
`endif

  always_comb begin
    stateN    = state;
    wrPtrN    = wrPtr;
    rdPtrN    = rdPtr;
    lineLenN  = lineLen;
    outValidN = outValid;
    outDataN  = outData;
    outLastN  = outLast;
    overflowN = overflow;
    dropN     = 1'b0;
    memWe     = 1'b0;

    unique case (state)
      FILL: begin
        if (bus.in_valid) begin
          if (isTerm) begin
            // An empty line (or the LF of a CRLF pair) produces nothing.
            if (wrPtr != '0) begin
              lineLenN = wrPtr;
              rdPtrN   = '0;
              stateN   = LOAD;
            end
          end else if (isBackspace) begin
            if (wrPtr != '0) begin
              wrPtrN = wrPtr - One;
            end
          end else if (wrPtr < MaxLen) begin
            memWe  = 1'b1;
            wrPtrN = wrPtr + One;
          end else begin
            overflowN = 1'b1;
          end
        end
      end

      LOAD: begin
        outDataN  = mem[rdPtr[AW-1:0]];
        outValidN = 1'b1;
        outLastN  = (rdPtr == lastIdx);
        stateN    = DRAIN;
      end

      DRAIN: begin
        if (outValid && bus.out_ready) begin
          if (outLast) begin
            outValidN = 1'b0;
            outLastN  = 1'b0;
            wrPtrN    = '0;
            overflowN = 1'b0;
            stateN    = FILL;
          end else begin
            // Prefetch the following byte so a ready consumer sees no bubble.
            rdPtrN   = rdNext;
            outDataN = mem[rdNext[AW-1:0]];
            outLastN = (rdNext == lastIdx);
          end
        end
      end

      default: begin
        stateN = FILL;
      end
    endcase

    if (bus.in_valid && (state != FILL)) begin
      dropN = 1'b1;
    end

    busyN = (stateN != FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      wrPtr    <= '0;
      rdPtr    <= '0;
      lineLen  <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      outLast  <= 1'b0;
      overflow <= 1'b0;
      drop     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= stateN;
      wrPtr    <= wrPtrN;
      rdPtr    <= rdPtrN;
      lineLen  <= lineLenN;
      outValid <= outValidN;
      outData  <= outDataN;
      outLast  <= outLastN;
      overflow <= overflowN;
      drop     <= dropN;
      busy     <= busyN;
    end
  end

  // Line storage carries no reset; a line is only readable once wrPtr has covered it.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wrPtr[AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.out_valid = outValid;
  assign bus.out_data  = outData;
  assign bus.out_last  = outLast;
  assign bus.line_len  = lineLen;
  assign bus.overflow  = overflow;
  assign bus.drop      = drop;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Scoreboard bench for uart_line_buffer: a line-level reference model queues expected
// output bytes as input bytes are issued; a monitor pops and compares on every transfer.
module tb_uart_line_buffer;

  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 3;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         len;
    logic       ov;
  } exp_t;

  logic clk;
  logic rst;

  uart_line_buffer_if #(.LEN_W(LEN_W)) bus ();

  uart_line_buffer #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  exp_t       expQ[$];
  logic [7:0] cur[$];
  logic       curOv     = 1'b0;
  logic       lineBusy  = 1'b0;
  logic       expDrop   = 1'b0;
  int         sinceTerm = -1;
  logic       prevValid = 1'b0;
  logic       prevReady = 1'b0;
  logic       prevLast  = 1'b0;
  logic [7:0] prevData  = 8'h00;

  int readyMode = 2;  // 0: always ready, 1: random, 2: never, other: driven by stimulus

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Consumer readiness driver
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'($urandom_range(0, 1));
        2: bus.out_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Reference model plus monitor, evaluated mid-cycle before each sampling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        cur.delete();
        curOv     = 1'b0;
        lineBusy  = 1'b0;
        expDrop   = 1'b0;
        sinceTerm = -1;
        prevValid = 1'b0;
        prevReady = 1'b0;
        prevLast  = 1'b0;
      end else begin
        chk("busy", bus.busy, lineBusy);
        chk("drop", bus.drop, expDrop);
        expDrop = 1'b0;

        if (sinceTerm >= 0) begin
          sinceTerm++;
          if (sinceTerm == 1) begin
            chk("latency_early", bus.out_valid, 0);
          end else begin
            chk("latency", bus.out_valid, 1);
            sinceTerm = -1;
          end
        end

        if (prevValid && !prevReady) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_data", bus.out_data, prevData);
          chk("hold_last", bus.out_last, prevLast);
        end else if (prevValid && prevReady && !prevLast) begin
          chk("no_bubble", bus.out_valid, 1);
        end
        prevValid = bus.out_valid;
        prevReady = bus.out_ready;
        prevLast  = bus.out_last;
        prevData  = bus.out_data;

        // Byte about to be sampled by the DUT
        if (bus.in_valid) begin
          if (lineBusy) begin
            expDrop = 1'b1;
          end else if (bus.in_data == 8'h0D || bus.in_data == 8'h0A) begin
            if (cur.size() > 0) begin
              for (int i = 0; i < cur.size(); i++) begin
                exp_t e;
                e.data = cur[i];
                e.last = (i == cur.size() - 1);
                e.len  = cur.size();
                e.ov   = curOv;
                expQ.push_back(e);
              end
              cur.delete();
              curOv     = 1'b0;
              lineBusy  = 1'b1;
              sinceTerm = 0;
            end
`ifdef LINE_BUF_BACKSPACE_EN
          end else if (bus.in_data == 8'h08 || bus.in_data == 8'h7F) begin
            if (cur.size() > 0) void'(cur.pop_back());
`endif
          end else if (cur.size() < MAX_LEN) begin
            cur.push_back(bus.in_data);
          end else begin
            curOv = 1'b1;
          end
        end

        // Transfer about to happen on the output
        if (bus.out_valid && bus.out_ready) begin
          if (expQ.size() == 0) begin
            chk("spurious_out", bus.out_data, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = expQ.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_last", bus.out_last, e.last);
            chk("line_len", bus.line_len, e.len);
            chk("overflow", bus.overflow, e.ov);
            if (e.last) lineBusy = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic sendStr(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) sendByte(s[i], gap);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((expQ.size() != 0 || lineBusy) && n < 3000) begin
      tick();
      n++;
    end
    chk(name, (expQ.size() == 0 && !lineBusy), 1);
    repeat (2) tick();
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk(name, bus.out_valid, 1);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"},  bus.out_data,  0);
    chk({tag, "_out_last"},  bus.out_last,  0);
    chk({tag, "_line_len"},  bus.line_len,  0);
    chk({tag, "_overflow"},  bus.overflow,  0);
    chk({tag, "_drop"},      bus.drop,      0);
    chk({tag, "_busy"},      bus.busy,      0);
  endtask

  initial begin
    int dropSeen;
    logic [7:0] b;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) tick();
    checkReset("por");
    rst = 1'b0;
    readyMode = 0;
    repeat (2) tick();

    // Slow single line, consumer always ready
    sendStr("LED", 233);
    sendByte(8'h0D, 233);
    waitIdle("led_idle");

    // CRLF and a trailing LF: two lines, nothing for the bare LF
    sendStr("AB", 20);
    sendByte(8'h0D, 20);
    sendByte(8'h0A, 20);
    sendStr("C", 20);
    sendByte(8'h0A, 20);
    waitIdle("crlf_idle");

    // Overflow past MAX_LEN
    sendStr("123456", 1);
    chk("ovf_fill", bus.overflow, 1);
    sendByte(8'h0A, 0);
    waitIdle("ovf_idle");
    chk("ovf_clear", bus.overflow, 0);

    // Consumer stalls for 10 cycles while a byte arrives
    readyMode = 2;
    sendStr("HI", 0);
    sendByte(8'h0D, 0);
    waitValid("hold_wait");
    dropSeen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (bus.drop) dropSeen++;
    end
    bus.in_valid = 1'b0;
    chk("drop_once", dropSeen, 1);
    readyMode = 0;
    waitIdle("hold_idle");

    // Reset in the middle of filling
    sendStr("XY", 1);
    rst = 1'b1;
    #1;
    checkReset("rst_fill");
    tick();
    rst = 1'b0;
    tick();
    sendStr("Q", 0);
    sendByte(8'h0A, 0);
    waitIdle("rst_fill_idle");

    // Reset after one of three bytes has drained
    readyMode = 2;
    sendStr("abc", 0);
    sendByte(8'h0D, 0);
    waitValid("rst_drain_wait");
    readyMode = 4;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("rst_drain_pre", bus.out_valid, 1);
    rst = 1'b1;
    #1;
    checkReset("rst_drain");
    tick();
    rst = 1'b0;
    readyMode = 0;
    tick();
    sendStr("Q", 0);
    sendByte(8'h0A, 0);
    waitIdle("rst_drain_idle");

    // Backspace handling (erases with the feature, stored without)
    sendStr("AB", 0);
    sendByte(8'h08, 0);
    sendStr("C", 0);
    sendByte(8'h0D, 0);
    waitIdle("bs_idle");

    // Randomized traffic with a random consumer
    readyMode = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 11))
        0:       b = 8'h0D;
        1:       b = 8'h0A;
        2:       b = 8'h08;
        3:       b = 8'h7F;
        default: b = 8'h61 + 8'($urandom_range(0, 25));
      endcase
      sendByte(b, $urandom_range(0, 3));
    end
    sendByte(8'h0A, 0);
    waitIdle("rand_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
